// File: rtl/cache_flush_controller_pkg.sv
// Shared cache-subsystem definitions: coherence states,
// line status bit positions and the flush FSM encoding.
package cache_flush_controller_pkg;

  localparam logic [1:0] SHARED    = 2'b01;
  localparam logic [1:0] EXCLUSIVE = 2'b10;
  localparam logic [1:0] MODIFIED  = 2'b11;

  localparam int VALID_BIT = 1;
  localparam int DIRTY_BIT = 0;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CHECK,
    WRITEBACK,
    INVAL,
    DONE
  } flush_state_e;

endpackage

// File: rtl/cache_flush_controller_walk.sv
// Set/way walker: way increments first, wrapping into the
// next set; last flags the final way of the final set.
module line_walk_counter #(
  parameter int INDEX_BITS     = 8,
  parameter int WAY_BITS       = 2,
  parameter int NUMBER_OF_WAYS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  advance,
  output logic [INDEX_BITS-1:0] index,
  output logic [WAY_BITS-1:0]   way_select,
  output logic                  last
);

  localparam logic [WAY_BITS-1:0] LAST_WAY =
    WAY_BITS'(NUMBER_OF_WAYS - 1);

  logic last_way;

  assign last_way = (way_select == LAST_WAY);
  assign last     = last_way && (index == '1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      index      <= '0;
      way_select <= '0;
    end else if (advance) begin
      if (last_way) begin
        way_select <= '0;
        index      <= index + 1'b1;
      end else begin
        way_select <= way_select + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_flush_controller.sv
// Walks every cache line, writing back valid+dirty lines and
// optionally invalidating each visited line.
module cache_flush_controller
  import cache_flush_controller_pkg::*;
#(
  parameter int STATUS_BITS    = 2,
  parameter int COHERENCE_BITS = 2,
  parameter int OFFSET_BITS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int NUMBER_OF_WAYS = 4,
  parameter int ADDRESS_BITS   = 32,
  parameter int INDEX_BITS     = 8,
  parameter bit INVALIDATE_ON_FLUSH = 1'b1,
  localparam int BLOCK_WIDTH = DATA_WIDTH << OFFSET_BITS,
  localparam int TAG_BITS =
    ADDRESS_BITS - OFFSET_BITS - INDEX_BITS,
  localparam int WAY_BITS =
    (NUMBER_OF_WAYS > 1) ? $clog2(NUMBER_OF_WAYS) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    flush_req,
  output logic                    busy,
  output logic                    flush_done,
  output logic                    read,
  output logic                    invalidate,
  output logic [INDEX_BITS-1:0]   index,
  output logic [WAY_BITS-1:0]     way_select,
  input  logic [BLOCK_WIDTH-1:0]  data_out,
  input  logic [TAG_BITS-1:0]     tag_out,
  input  logic [STATUS_BITS-1:0]  status_bits,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [ADDRESS_BITS-1:0] wb_address,
  output logic [BLOCK_WIDTH-1:0]  wb_data
);

  if (STATUS_BITS < 2 || COHERENCE_BITS < 1) begin : g_bad_cfg
    $error("status field needs valid and dirty bits");
  end

  flush_state_e state;
  logic start;
  logic dirty;
  logic advance;
  logic last;

  assign start = (state == IDLE) && flush_req;
  assign dirty = status_bits[VALID_BIT]
               & status_bits[DIRTY_BIT];

  // The walk steps on the cycle a line is finished with.
  assign advance = INVALIDATE_ON_FLUSH
    ? (state == INVAL)
    : ((state == CHECK && !dirty) ||
       (state == WRITEBACK && wb_ready));

  line_walk_counter #(
    .INDEX_BITS    (INDEX_BITS),
    .WAY_BITS      (WAY_BITS),
    .NUMBER_OF_WAYS(NUMBER_OF_WAYS)
  ) u_walk (
    .clock     (clock),
    .reset     (reset),
    .clear     (start),
    .advance   (advance),
    .index     (index),
    .way_select(way_select),
    .last      (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      flush_done <= 1'b0;
      read       <= 1'b0;
      invalidate <= 1'b0;
      wb_valid   <= 1'b0;
      wb_address <= '0;
      wb_data    <= '0;
    end else begin
      read       <= 1'b0;
      invalidate <= 1'b0;
      flush_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (flush_req) begin
            state <= READ;
            read  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: state <= CHECK;
        CHECK: begin
          wb_address <= {tag_out, index,
                         {OFFSET_BITS{1'b0}}};
          wb_data    <= data_out;
          if (dirty) begin
            state    <= WRITEBACK;
            wb_valid <= 1'b1;
          end else if (INVALIDATE_ON_FLUSH) begin
            state      <= INVAL;
            invalidate <= 1'b1;
          end else begin
            state      <= last ? DONE : READ;
            read       <= !last;
            flush_done <= last;
          end
        end
        WRITEBACK: begin
          if (wb_ready) begin
            wb_valid <= 1'b0;
            if (INVALIDATE_ON_FLUSH) begin
              state      <= INVAL;
              invalidate <= 1'b1;
            end else begin
              state      <= last ? DONE : READ;
              read       <= !last;
              flush_done <= last;
            end
          end
        end
        INVAL: begin
          state      <= last ? DONE : READ;
          read       <= !last;
          flush_done <= last;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_flush_controller.sv
// Randomized bench: two controllers (invalidate on/off) over
// a behavioural cache, checked against per-line expectations.
module tb_cache_flush_controller;

  localparam int IB    = 2;
  localparam int NW    = 4;
  localparam int WB    = 2;
  localparam int TBITS = 28;
  localparam int BW    = 128;
  localparam int AW    = 32;
  localparam int LINES = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic flush_req = 1'b0;
  logic wb_ready = 1'b0;
  bit   sel = 1'b0;

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0]    m_data [LINES];
  logic [TBITS-1:0] m_tag  [LINES];
  logic [1:0]       m_stat [LINES];

  logic a_req, a_busy, a_done, a_read, a_inv, a_wbv;
  logic [IB-1:0] a_index;
  logic [WB-1:0] a_way;
  logic [BW-1:0] a_dout, a_wdata;
  logic [TBITS-1:0] a_tag;
  logic [1:0] a_stat;
  logic [AW-1:0] a_addr;

  logic b_req, b_busy, b_done, b_read, b_inv, b_wbv;
  logic [IB-1:0] b_index;
  logic [WB-1:0] b_way;
  logic [BW-1:0] b_dout, b_wdata;
  logic [TBITS-1:0] b_tag;
  logic [1:0] b_stat;
  logic [AW-1:0] b_addr;

  assign a_req = flush_req & ~sel;
  assign b_req = flush_req & sel;

  cache_flush_controller #(
    .INDEX_BITS(IB), .INVALIDATE_ON_FLUSH(1'b1)
  ) u_a (
    .clock(clock), .reset(reset), .flush_req(a_req),
    .busy(a_busy), .flush_done(a_done), .read(a_read),
    .invalidate(a_inv), .index(a_index),
    .way_select(a_way), .data_out(a_dout),
    .tag_out(a_tag), .status_bits(a_stat),
    .wb_valid(a_wbv), .wb_ready(wb_ready),
    .wb_address(a_addr), .wb_data(a_wdata)
  );

  cache_flush_controller #(
    .INDEX_BITS(IB), .INVALIDATE_ON_FLUSH(1'b0)
  ) u_b (
    .clock(clock), .reset(reset), .flush_req(b_req),
    .busy(b_busy), .flush_done(b_done), .read(b_read),
    .invalidate(b_inv), .index(b_index),
    .way_select(b_way), .data_out(b_dout),
    .tag_out(b_tag), .status_bits(b_stat),
    .wb_valid(b_wbv), .wb_ready(wb_ready),
    .wb_address(b_addr), .wb_data(b_wdata)
  );

  // Cache arrays answer one cycle after read.
  always @(posedge clock) begin
    if (a_read) begin
      a_dout <= m_data[{a_index, a_way}];
      a_tag  <= m_tag[{a_index, a_way}];
      a_stat <= m_stat[{a_index, a_way}];
    end
    if (b_read) begin
      b_dout <= m_data[{b_index, b_way}];
      b_tag  <= m_tag[{b_index, b_way}];
      b_stat <= m_stat[{b_index, b_way}];
    end
  end

  logic v_busy, v_done, v_read, v_inv, v_wbv;
  logic [IB-1:0] v_index;
  logic [WB-1:0] v_way;
  logic [AW-1:0] v_addr;
  logic [BW-1:0] v_wdata;

  assign v_busy  = sel ? b_busy  : a_busy;
  assign v_done  = sel ? b_done  : a_done;
  assign v_read  = sel ? b_read  : a_read;
  assign v_inv   = sel ? b_inv   : a_inv;
  assign v_wbv   = sel ? b_wbv   : a_wbv;
  assign v_index = sel ? b_index : a_index;
  assign v_way   = sel ? b_way   : a_way;
  assign v_addr  = sel ? b_addr  : a_addr;
  assign v_wdata = sel ? b_wdata : a_wdata;

  // kind: 0 clean mix, 1 any status, 2 all valid+clean
  task automatic fill(input int kind);
    for (int l = 0; l < LINES; l++) begin
      m_data[l] = {$urandom, $urandom, $urandom, $urandom};
      m_tag[l]  = TBITS'($urandom);
      case (kind)
        0:       m_stat[l] = 2'($urandom_range(0, 2));
        1:       m_stat[l] = 2'($urandom);
        default: m_stat[l] = 2'b10;
      endcase
    end
  endtask

  // mode: 0 ready tied 1, 1 random ready, 2 five-cycle stall
  task automatic run_flush(
    input int mode, input bit again, input bit rst_wb,
    output int busy_n, output int wb_n, output int inv_n,
    output int wbv_n, output bit rst_hit,
    output logic [AW-1:0] last_addr,
    output logic [BW-1:0] last_data
  );
    int exp_line[$];
    int exp_inv[$];
    logic [AW-1:0] exp_addr[$];
    logic [BW-1:0] exp_data[$];
    logic [AW-1:0] h_addr, ea;
    logic [BW-1:0] h_data, ed;
    bit inv_en, done, hold, after_hs, ok;
    int stalls, run, excl_bad, ndirty, e, extra, exp_busy;
    busy_n = 0; wb_n = 0; inv_n = 0; wbv_n = 0;
    rst_hit = 0; last_addr = '0; last_data = '0;
    done = 0; hold = 0; after_hs = 0;
    stalls = 0; run = 0; excl_bad = 0; ndirty = 0;
    h_addr = '0; h_data = '0;
    inv_en = !sel;
    for (int l = 0; l < LINES; l++) begin
      exp_line.push_back(l);
      if (inv_en) exp_inv.push_back(l);
      if (m_stat[l] == 2'b11) begin
        ndirty++;
        exp_addr.push_back({m_tag[l], 2'(l / NW), 2'b00});
        exp_data.push_back(m_data[l]);
      end
    end
    @(negedge clock);
    flush_req = 1'b1;
    @(negedge clock);
    flush_req = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (v_busy) busy_n++;
      if (v_wbv) wbv_n++;
      if ((int'(v_read) + int'(v_inv) + int'(v_wbv)) > 1 ||
          (!v_busy && (v_read || v_inv || v_wbv)))
        excl_bad++;
      if (hold) begin
        n_tests++;
        if ({v_wbv, v_addr, v_wdata} !==
            {1'b1, h_addr, h_data}) begin
          n_fail++;
          $display("FAIL wb_hold: got v=%b a=%h want a=%h",
                   v_wbv, v_addr, h_addr);
        end
      end
      if (after_hs) begin
        n_tests++;
        ok = inv_en ? v_inv : (v_read | v_done);
        if (ok !== 1'b1) begin
          n_fail++;
          $display("FAIL resume: got %b want 1", ok);
        end
        after_hs = 0;
      end
      if (v_read) begin
        n_tests++;
        if (exp_line.size() == 0) begin
          n_fail++;
          $display("FAIL read_order: got extra read want none");
        end else begin
          e = exp_line.pop_front();
          if ({v_index, v_way} !== 4'(e)) begin
            n_fail++;
            $display("FAIL read_order: got %0d want %0d",
                     {v_index, v_way}, e);
          end
        end
      end
      if (v_inv) begin
        inv_n++;
        n_tests++;
        if (exp_inv.size() == 0) begin
          n_fail++;
          $display("FAIL inval: got extra invalidate want none");
        end else begin
          e = exp_inv.pop_front();
          if ({v_index, v_way} !== 4'(e)) begin
            n_fail++;
            $display("FAIL inval: got %0d want %0d",
                     {v_index, v_way}, e);
          end
        end
      end
      if (v_done) begin
        done = 1;
        break;
      end
      flush_req = again && busy_n >= 10 && busy_n <= 12;
      if (rst_wb && v_wbv && run == 2) begin
        rst_hit = 1;
        wb_ready = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        n_tests++;
        if ({v_busy, v_wbv, v_done, v_read, v_inv} !== 5'b0)
        begin
          n_fail++;
          $display("FAIL rst_ctl: got %b want 00000",
                   {v_busy, v_wbv, v_done, v_read, v_inv});
        end
        n_tests++;
        if ({v_index, v_way, v_addr, v_wdata} !== '0) begin
          n_fail++;
          $display("FAIL rst_data: got a=%h want 0", v_addr);
        end
        extra = 0;
        repeat (30) begin
          @(negedge clock);
          if (v_busy || v_done) extra++;
        end
        n_tests++;
        if (extra != 0) begin
          n_fail++;
          $display("FAIL rst_resume: got %0d busy cycles want 0",
                   extra);
        end
        return;
      end
      if (v_wbv)
        wb_ready = (mode == 0) ? 1'b1 :
                   (mode == 1) ? 1'($urandom_range(0, 1)) :
                   (run == 5);
      else
        wb_ready = (mode == 0) ? 1'b1 :
                   1'($urandom_range(0, 1));
      hold = 0;
      if (v_wbv) begin
        if (wb_ready) begin
          wb_n++;
          n_tests++;
          if (exp_addr.size() == 0) begin
            n_fail++;
            $display("FAIL wb_line: got extra writeback want none");
          end else begin
            ea = exp_addr.pop_front();
            ed = exp_data.pop_front();
            if (v_addr !== ea || v_wdata !== ed) begin
              n_fail++;
              $display("FAIL wb_line: got %h want %h",
                       v_addr, ea);
            end
          end
          last_addr = v_addr;
          last_data = v_wdata;
          after_hs = 1;
          run = 0;
        end else begin
          stalls++;
          run++;
          hold = 1;
          h_addr = v_addr;
          h_data = v_wdata;
        end
      end
    end
    n_tests++;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: got no flush_done want one");
    end
    exp_busy = LINES * (inv_en ? 3 : 2) + ndirty + stalls + 1;
    n_tests++;
    if (busy_n != exp_busy) begin
      n_fail++;
      $display("FAIL latency: got %0d want %0d",
               busy_n, exp_busy);
    end
    n_tests++;
    e = exp_line.size() + exp_inv.size() + exp_addr.size();
    if (e != 0) begin
      n_fail++;
      $display("FAIL coverage: got %0d lines left want 0", e);
    end
    n_tests++;
    if (excl_bad != 0) begin
      n_fail++;
      $display("FAIL exclusive: got %0d bad cycles want 0",
               excl_bad);
    end
    extra = 0;
    repeat (6) begin
      @(negedge clock);
      if (v_busy || v_done) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL after_done: got %0d busy/done want 0",
               extra);
    end
  endtask

  int bn, wn, inn, wv;
  bit rh;
  logic [AW-1:0] la;
  logic [BW-1:0] ld;

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    n_tests++;
    if ({a_busy, a_done, a_read, a_inv, a_wbv} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_a_ctl: got %b want 0",
               {a_busy, a_done, a_read, a_inv, a_wbv});
    end
    n_tests++;
    if ({a_index, a_way, a_addr, a_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_a_data: got %h want 0", a_addr);
    end
    n_tests++;
    if ({b_busy, b_done, b_read, b_inv, b_wbv} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_b_ctl: got %b want 0",
               {b_busy, b_done, b_read, b_inv, b_wbv});
    end
    n_tests++;
    if ({b_index, b_way, b_addr, b_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_b_data: got %h want 0", b_addr);
    end
    reset = 1'b0;
  endtask

  task automatic test_clean_flush();
    sel = 0;
    fill(0);
    run_flush(0, 0, 0, bn, wn, inn, wv, rh, la, ld);
    n_tests++;
    if (wv != 0 || inn != 16 || bn != 49) begin
      n_fail++;
      $display("FAIL clean: got wbv=%0d inv=%0d busy=%0d want 0 16 49",
               wv, inn, bn);
    end
  endtask

  task automatic test_single_dirty();
    sel = 0;
    fill(2);
    m_stat[7] = 2'b11;
    m_tag[7]  = 28'h3BBBB80;
    run_flush(0, 0, 0, bn, wn, inn, wv, rh, la, ld);
    n_tests++;
    if (wn != 1 || la !== 32'h3BBBB804 || ld !== m_data[7])
    begin
      n_fail++;
      $display("FAIL dirty_line: got n=%0d a=%h want 1 3bbbb804",
               wn, la);
    end
  endtask

  task automatic test_stall();
    sel = 0;
    fill(2);
    m_stat[5] = 2'b11;
    run_flush(2, 0, 0, bn, wn, inn, wv, rh, la, ld);
    n_tests++;
    if (bn != 55 || wv != 6) begin
      n_fail++;
      $display("FAIL stall: got busy=%0d wbv=%0d want 55 6",
               bn, wv);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      sel = i[0];
      fill(1);
      run_flush(1, 0, 0, bn, wn, inn, wv, rh, la, ld);
    end
  endtask

  task automatic test_reflush_ignored();
    sel = 0;
    fill(1);
    run_flush(1, 1, 0, bn, wn, inn, wv, rh, la, ld);
  endtask

  task automatic test_reset_mid_wb();
    sel = 0;
    fill(2);
    m_stat[2] = 2'b11;
    run_flush(2, 0, 1, bn, wn, inn, wv, rh, la, ld);
    n_tests++;
    if (!rh) begin
      n_fail++;
      $display("FAIL rst_wb_reach: got 0 want 1");
    end
  endtask

  task automatic test_no_invalidate();
    sel = 1;
    fill(2);
    run_flush(0, 0, 0, bn, wn, inn, wv, rh, la, ld);
    n_tests++;
    if (inn != 0 || bn != 33 || wv != 0) begin
      n_fail++;
      $display("FAIL no_inval: got inv=%0d busy=%0d want 0 33",
               inn, bn);
    end
  endtask

  initial begin
    test_reset();
    test_clean_flush();
    test_single_dirty();
    test_stall();
    test_random();
    test_reflush_ignored();
    test_reset_mid_wb();
    test_no_invalidate();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
